bus_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one 32-bit data bus among up to eight requesters in the P7 CPU bridge. It registers a one-hot grant and drives the 3-bit select of the 8:1 32-bit bus multiplexer, so the owner's data reaches the shared bus. Ownership lasts until release or hold timeout. A mandatory one-cycle turnaround separates owners.

---
 rtl/bus_rr_arbiter.sv | 95 +++++++++
 tb/tb_bus_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner arbiter for the P7 bridge 8:1 data bus mux.
// One-hot grant, held until release or hold limit, one idle turnaround cycle.
module bus_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic [7:0] rel,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [7:0]       r_grant;
  logic [2:0]       r_sel;
  logic [2:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_timeout;

  logic       w_any;
  logic [2:0] w_win;
  logic       w_vol;
  logic       w_lim;

  // Reverse scan so the candidate nearest to ptr is written last and wins.
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int k = 7; k >= 0; k--) begin
      if (req[r_ptr + 3'(k)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 3'(k);
      end
    end
  end

  assign w_vol = rel[r_sel] | ~req[r_sel];
  assign w_lim = (MAX_HOLD != 0) && (r_cnt == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_grant <= 8'b1 << w_win;
            r_sel   <= w_win;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_GRANT: begin
          if (w_vol || w_lim) begin
            r_state   <= S_IDLE;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_ptr     <= r_sel + 3'd1;
            r_cnt     <= '0;
            r_timeout <= ~w_vol;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: directed scenarios plus random traffic,
// all checked every cycle against an ownership-level reference model.
module tb_bus_rr_arbiter;

  localparam int M = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] rel = 8'h00;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  bus_rr_arbiter #(.MAX_HOLD(M), .CNT_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .rel(rel),
    .grant(grant),
    .sel(sel),
    .busy(busy),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus and for how many cycles so far.
  int owner = -1;
  int held  = 0;
  int ptr   = 0;
  int lsel  = 0;
  bit m_to  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      owner = -1; held = 0; ptr = 0; lsel = 0; m_to = 1'b0;
    end else if (owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (owner < 0 && req[(ptr + k) % 8]) begin
          owner = (ptr + k) % 8;
          lsel  = owner;
          held  = 1;
        end
      end
    end else begin
      bit vol;
      bit lim;
      vol  = rel[owner] || !req[owner];
      lim  = (M != 0) && (held >= M);
      m_to = 1'b0;
      if (vol || lim) begin
        m_to  = !vol;
        ptr   = (owner + 1) % 8;
        owner = -1;
        held  = 0;
      end else begin
        held++;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [12:0] act;
      logic [12:0] exp;
      act = {grant, sel, busy, timeout};
      exp = {(owner >= 0) ? (8'h01 << owner) : 8'h00,
             3'(lsel), owner >= 0, m_to};
      n_tests++;
      if (act !== exp) begin
        n_fail++;
        $display("FAIL model t=%0t {grant,sel,busy,to} got %h/%0d/%b/%b want %h/%0d/%b/%b",
                 $time, act[12:5], act[4:2], act[1], act[0],
                 exp[12:5], exp[4:2], exp[1], exp[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [12:0] a,
                     input logic [12:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  function automatic logic [12:0] outs();
    return {grant, sel, busy, timeout};
  endfunction

  function automatic logic [12:0] xp(input logic [7:0] g,
                                     input logic [2:0] s,
                                     input logic b, input logic t);
    return {g, s, b, t};
  endfunction

  logic [7:0] rr_exp [4] = '{8'h01, 8'h04, 8'h80, 8'h01};

  initial begin
    // Reset held with all requests active.
    reset = 1'b1; req = 8'hFF;
    cyc(); cyc();
    chk("reset", outs(), xp(8'h00, 3'd0, 1'b0, 1'b0));
    reset = 1'b0; req = 8'h00;
    cyc(); cyc();
    chk("idle", outs(), xp(8'h00, 3'd0, 1'b0, 1'b0));

    // Single requester, release, turnaround, re-grant.
    req = 8'h08;
    cyc();
    chk("single_grant", outs(), xp(8'h08, 3'd3, 1'b1, 1'b0));
    rel = 8'h08;
    cyc();
    chk("single_rel", outs(), xp(8'h00, 3'd3, 1'b0, 1'b0));
    rel = 8'h00;
    cyc();
    chk("single_regrant", outs(), xp(8'h08, 3'd3, 1'b1, 1'b0));
    req = 8'h00;
    cyc();

    // Round robin from ptr=0.
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 8'h85;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rr_grant", {grant, 5'd0}, {rr_exp[i], 5'd0});
      cyc();
      rel = rr_exp[i];
      cyc();
      chk("rr_turn", {grant, 5'd0}, 13'd0);
      rel = 8'h00;
    end
    req = 8'h00;
    cyc(); cyc();

    // Hold timeout and re-grant.
    reset = 1'b1; cyc(); reset = 1'b0;
    req = 8'h02;
    cyc();
    chk("to_c1", outs(), xp(8'h02, 3'd1, 1'b1, 1'b0));
    cyc(); cyc(); cyc();
    chk("to_c4", outs(), xp(8'h02, 3'd1, 1'b1, 1'b0));
    cyc();
    chk("to_pulse", outs(), xp(8'h00, 3'd1, 1'b0, 1'b1));
    cyc();
    chk("to_regrant", outs(), xp(8'h02, 3'd1, 1'b1, 1'b0));
    req = 8'h22;
    cyc(); cyc(); cyc();
    cyc();
    chk("to_pulse2", outs(), xp(8'h00, 3'd1, 1'b0, 1'b1));
    cyc();
    chk("to_fair", outs(), xp(8'h20, 3'd5, 1'b1, 1'b0));
    req = 8'h02;
    cyc();
    chk("drop_rel", outs(), xp(8'h00, 3'd5, 1'b0, 1'b0));
    cyc();
    chk("own1", outs(), xp(8'h02, 3'd1, 1'b1, 1'b0));

    // Non-owner release ignored; voluntary release beats limit.
    rel = 8'hFD;
    cyc(); cyc();
    chk("rel_ignored", outs(), xp(8'h02, 3'd1, 1'b1, 1'b0));
    rel = 8'h00;
    cyc();
    rel = 8'h02;
    cyc();
    chk("rel_prec", outs(), xp(8'h00, 3'd1, 1'b0, 1'b0));
    rel = 8'h00;

    // Reset during ownership, then ptr restart at 0.
    req = 8'h40;
    cyc();
    chk("own6", outs(), xp(8'h40, 3'd6, 1'b1, 1'b0));
    reset = 1'b1;
    cyc();
    chk("mid_reset", outs(), xp(8'h00, 3'd0, 1'b0, 1'b0));
    reset = 1'b0; req = 8'h41;
    cyc();
    chk("post_reset", outs(), xp(8'h01, 3'd0, 1'b1, 1'b0));

    // Random traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      rel   = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      reset = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0; req = 8'h00; rel = 8'h00;
    cyc(); cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
